axis_pkt_fifo: RTL and testbench

- Single-clock, store-and-forward AXI-Stream packet FIFO with generic data width and depth.
- Only complete, good frames become visible on the read side. Frames flagged bad by tuser, or that overflow, are rolled back and never reach the reader.
- Sits between the RX MAC CDC stage and user logic, and in front of protocol parsers (IP/UDP) that need whole frames.
- Mode parameter selects between dropping on overflow (MAC-facing, no backpressure) and upstream backpressure.

---
 rtl/axis_pkt_fifo.sv | 175 +++++++++++++++++
 tb/tb_axis_pkt_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo -- single-clock store-and-forward AXI-Stream packet FIFO.
//
// A frame becomes visible to the reader only after its tlast beat is written
// with tuser=0. Frames flagged bad, and frames that overflow the storage, are
// rolled back by rewinding the write pointer to the last commit point.
//
// Parameters
//   DATA_WIDTH      tdata width
//   FIFO_DEPTH      storage words (power of 2, >= 4)
//   DROP_WHEN_FULL  1: s_axis_tready held high, overflowing frames are dropped
//                   0: s_axis_tready = !full (backpressure)
//
// Ports
//   i_clk, i_reset_n           clock, async active-low reset
//   s_axis_t{data,valid,last,user,ready}  write side (tuser = frame error,
//                                          sampled on the tlast beat only)
//   m_axis_t{data,valid,last,ready}       read side, registered output
//   o_pkt_count  complete frames held (incl. the one in the output register)
//   o_fill       words occupied in storage, committed plus in-progress
//   o_drop       one-cycle pulse per dropped frame
//   o_drop_cnt   saturating dropped-frame counter, present only when
//                AXIS_PKT_FIFO_DROP_CNT_EN is defined
module axis_pkt_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 2048,
  parameter int DROP_WHEN_FULL = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tuser,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   o_pkt_count,
  output logic [$clog2(FIFO_DEPTH):0]   o_fill,
  output logic                          o_drop
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]                   o_drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_W = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] ONE_W   = PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DROP} wr_state_e;

  wr_state_e             state_q, state_d;
  logic [PW-1:0]         wr_ptr_cur, wr_ptr_commit, rd_ptr;
  logic [PW-1:0]         wr_cur_d, wr_commit_d;
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];

  logic full, oversize, accept, mem_we, commit, drop_d, rd_load, rd_pop;

  assign o_fill   = wr_ptr_cur - rd_ptr;
  assign full     = (o_fill == DEPTH_W);
  // Storage is entirely one unfinished frame and nothing is waiting at the
  // output: the frame can never fit, so it must be dropped even when
  // backpressuring, otherwise writer and reader deadlock.
  assign oversize = full && (wr_ptr_commit == rd_ptr) && !m_axis_tvalid;

  assign s_axis_tready = (DROP_WHEN_FULL != 0) || (state_q == S_DROP) || !full || oversize;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d     = state_q;
    wr_cur_d    = wr_ptr_cur;
    wr_commit_d = wr_ptr_commit;
    mem_we      = 1'b0;
    commit      = 1'b0;
    drop_d      = 1'b0;
    case (state_q)
      S_IDLE, S_ACTIVE: begin
        if (accept) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_cur_d = wr_ptr_cur + ONE_W;
            if (!s_axis_tlast) begin
              state_d = S_ACTIVE;
            end else if (s_axis_tuser) begin
              wr_cur_d = wr_ptr_commit;
              drop_d   = 1'b1;
              state_d  = S_IDLE;
            end else begin
              wr_commit_d = wr_ptr_cur + ONE_W;
              commit      = 1'b1;
              state_d     = S_IDLE;
            end
          end else begin
            // overflow: rewind, then swallow the remainder of the frame
            wr_cur_d = wr_ptr_commit;
            if (s_axis_tlast) begin
              drop_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_DROP;
            end
          end
        end
      end
      S_DROP: begin
        if (accept && s_axis_tlast) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      wr_ptr_cur    <= '0;
      wr_ptr_commit <= '0;
      o_drop        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_cur    <= wr_cur_d;
      wr_ptr_commit <= wr_commit_d;
      o_drop        <= drop_d;
    end
  end

  // storage has no reset so it can map onto block RAM
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wr_ptr_cur[AW-1:0]] <= {s_axis_tdata, s_axis_tlast};
  end

  // only committed words are readable, so a loaded frame never stalls mid-way
  assign rd_load = (!m_axis_tvalid || m_axis_tready) && (rd_ptr != wr_ptr_commit);
  assign rd_pop  = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (rd_load) begin
      {m_axis_tdata, m_axis_tlast} <= mem[rd_ptr[AW-1:0]];
      rd_ptr                       <= rd_ptr + ONE_W;
      m_axis_tvalid                <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pkt_count <= '0;
    end else begin
      case ({commit, rd_pop})
        2'b10:   o_pkt_count <= o_pkt_count + ONE_W;
        2'b01:   o_pkt_count <= o_pkt_count - ONE_W;
        default: o_pkt_count <= o_pkt_count;
      endcase
    end
  end

`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                            o_drop_cnt <= '0;
    else if (drop_d && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo. Two instances: u0 (depth 128, drop-when-full) and
// u1 (depth 16, backpressure). Only one instance is exercised at a time (cur);
// the reference model is a queue of the {data,last} beats of every frame the
// bench expects to be committed, in write order.
module tb_axis_pkt_fifo;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [7:0]    s_tdata;
  logic          s_tlast, s_tuser;
  logic [N-1:0]  s_tvalid, s_tready, m_tvalid, m_tlast, m_tready, o_drop;
  logic [7:0]    m_tdata [N];
  logic [7:0]    pkt     [N];
  logic [7:0]    fill    [N];

  int tests = 0, fails = 0;
  int cur = 0;
  bit rnd_rd = 1'b0;
  int obs_drop = 0, exp_drop = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DEP = (g == 0) ? 128 : 16;
    logic [$clog2(DEP):0] pc, fl;
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
    logic [15:0] dc;
`endif
    axis_pkt_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEP), .DROP_WHEN_FULL(g == 0 ? 1 : 0)) u_dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid[g]), .s_axis_tlast(s_tlast),
      .s_axis_tuser(s_tuser), .s_axis_tready(s_tready[g]),
      .m_axis_tdata(m_tdata[g]), .m_axis_tvalid(m_tvalid[g]), .m_axis_tlast(m_tlast[g]),
      .m_axis_tready(m_tready[g]),
      .o_pkt_count(pc), .o_fill(fl), .o_drop(o_drop[g])
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
      , .o_drop_cnt(dc)
`endif
    );
    assign pkt[g]  = 8'(pc);
    assign fill[g] = 8'(fl);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Read-side scoreboard: a handshake is visible at the negedge before the
  // edge that completes it (inputs only change just after posedges).
  always @(negedge clk) begin
    if (rst_n && m_tvalid[cur] && m_tready[cur]) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("rd_beat", {23'd0, m_tdata[cur], m_tlast[cur]}, {23'd0, mon_e});
      end
    end
    if (rst_n && o_drop[cur]) obs_drop++;
  end

  // random reader throttling
  initial forever begin
    @(posedge clk); #1;
    if (rnd_rd) m_tready[cur] = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Write one frame to instance g. ok says whether the frame is expected to be
  // committed (its beats go into the model) or dropped.
  task automatic send(input int g, input int len, input bit bad, input bit ok);
    logic [8:0] beats[$];
    bit acc;
    int n;
    for (int i = 0; i < len; i++) begin
      s_tdata     = 8'($urandom);
      s_tlast     = (i == len - 1);
      s_tuser     = (i == len - 1) ? bad : 1'($urandom);
      s_tvalid[g] = 1'b1;
      n = 0;
      do begin
        @(negedge clk); acc = s_tready[g];
        @(posedge clk); #1;
        n++;
      end while (!acc && n < 3000);
      if (!acc) chk("wr_timeout", 1, 0);
      beats.push_back({s_tdata, s_tlast});
    end
    s_tvalid[g] = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    if (ok) foreach (beats[i]) exp_q.push_back(beats[i]);
    else    exp_drop++;
  endtask

  task automatic drain(input int g);
    int n = 0;
    m_tready[g] = 1'b1;
    while (exp_q.size() != 0 && n < 5000) begin tick(); n++; end
    chk("drain_left", exp_q.size(), 0);
    tick(); tick();
  endtask

  initial begin
    rst_n = 1'b1; s_tdata = '0; s_tlast = 0; s_tuser = 0; s_tvalid = '0; m_tready = '0;
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < N; g++) begin
      chk("rst_tvalid", m_tvalid[g], 0);
      chk("rst_tlast", m_tlast[g], 0);
      chk("rst_tdata", m_tdata[g], 0);
      chk("rst_pkt", pkt[g], 0);
      chk("rst_fill", fill[g], 0);
      chk("rst_drop", o_drop[g], 0);
      chk("rst_tready", s_tready[g], 1);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // single 64-byte good frame, reader always ready
    cur = 0; m_tready[0] = 1'b1;
    chk("t1_pkt_before", pkt[0], 0);
    send(0, 64, 0, 1);
    chk("t1_valid_not_yet", m_tvalid[0], 0);
    chk("t1_pkt_commit", pkt[0], 1);
    tick();
    chk("t1_valid_after_1", m_tvalid[0], 1);
    drain(0);
    chk("t1_pkt_after", pkt[0], 0);
    chk("t1_fill_after", fill[0], 0);

    // bad frame, then a good one
    send(0, 20, 1, 0);
    tick(); tick();
    chk("t2_drop_pulse", obs_drop, exp_drop);
    chk("t2_fill", fill[0], 0);
    chk("t2_pkt", pkt[0], 0);
    send(0, 10, 0, 1);
    drain(0);

    // drop-mode overflow: 100 committed (99 in storage + 1 held at output),
    // a 40-byte frame fits 29 beats and overflows on beat 30
    m_tready[0] = 1'b0;
    send(0, 100, 0, 1);
    repeat (3) tick();
    chk("t3_held", m_tvalid[0], 1);
    chk("t3_fill_a", fill[0], 99);
    send(0, 40, 0, 0);
    tick(); tick();
    chk("t3_ovf_rollback", fill[0], 99);
    chk("t3_ovf_drop", obs_drop, exp_drop);
    chk("t3_pkt", pkt[0], 1);
    send(0, 29, 0, 1);
    tick();
    chk("t3_exact_full", fill[0], 128);
    chk("t3_pkt2", pkt[0], 2);
    drain(0);
    chk("t3_pkt_end", pkt[0], 0);

    // commit of a new frame on the same edge as the prior frame's tlast read
    m_tready[0] = 1'b0;
    send(0, 3, 0, 1);
    tick(); tick();
    chk("t5_pkt_before", pkt[0], 1);
    fork
      send(0, 3, 0, 1);
      m_tready[0] = 1'b1;
    join
    chk("t5_commit_and_pop", pkt[0], 1);
    drain(0);
    chk("t5_pkt_end", pkt[0], 0);

    // backpressure: two 8-byte frames plus a third with the reader stalled
    cur = 1; m_tready[1] = 1'b0;
    send(1, 8, 0, 1);
    send(1, 8, 0, 1);
    fork
      send(1, 8, 0, 1);
      begin
        repeat (4) tick();
        chk("t4_bp_stall", s_tready[1], 0);
        chk("t4_bp_full", fill[1], 16);
        m_tready[1] = 1'b1;
      end
    join
    drain(1);
    chk("t4_pkt_end", pkt[1], 0);

    // oversize frame in backpressure mode must be dropped, not deadlock
    m_tready[1] = 1'b0;
    send(1, 20, 0, 0);
    tick(); tick();
    chk("t4_oversize_drop", obs_drop, exp_drop);
    chk("t4_oversize_fill", fill[1], 0);
    chk("t4_oversize_rdy", s_tready[1], 1);
    send(1, 5, 0, 1);
    drain(1);

    // async reset in the middle of reading a 30-byte frame
    cur = 0; m_tready[0] = 1'b1;
    send(0, 30, 0, 1);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", m_tvalid[0], 0);
    chk("t6_rst_data", m_tdata[0], 0);
    chk("t6_rst_pkt", pkt[0], 0);
    chk("t6_rst_fill", fill[0], 0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t6_rdy_after", s_tready[0], 1);
    send(0, 12, 0, 1);
    drain(0);

    // randomized frames, random bad flags, random reader stalls
    for (int g = 0; g < N; g++) begin
      cur = g; rnd_rd = 1'b1;
      for (int f = 0; f < 25; f++) begin
        int len, n;
        bit bad;
        len = (g == 0) ? $urandom_range(1, 20) : $urandom_range(1, 16);
        bad = ($urandom_range(0, 3) == 0);
        n = 0;
        while (g == 0 && exp_q.size() > 108 && n < 3000) begin tick(); n++; end
        send(g, len, bad, !bad);
      end
      rnd_rd = 1'b0;
      tick();
      drain(g);
      chk("rnd_pkt_end", pkt[g], 0);
      chk("rnd_fill_end", fill[g], 0);
    end

    chk("drop_total", obs_drop, exp_drop);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
